// File: rtl/i2c_wb_sequencer.sv
// Wishbone master that initialises an OpenCores-style I2C master core, then runs single-byte register write/read commands.
// Define I2C_SEQ_IRQ_EN to make WAIT wait for the core interrupt instead of polling the status register.
module i2c_wb_sequencer #(
  parameter logic [15:0] PRESCALE = 16'h0063
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       start_i,
  input  logic       rnw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic [7:0] rd_data_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  input  logic       wbm_ack_i,
  input  logic       wbm_inta_i
);

  localparam logic [2:0] ADR_PRL = 3'd0;
  localparam logic [2:0] ADR_PRH = 3'd1;
  localparam logic [2:0] ADR_CTR = 3'd2;
  localparam logic [2:0] ADR_TXR = 3'd3;
  localparam logic [2:0] ADR_CR  = 3'd4;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

`ifdef I2C_SEQ_IRQ_EN
  localparam logic [7:0] CTR_INIT = 8'hC0;
`else
  localparam logic [7:0] CTR_INIT = 8'h80;
  logic unused_inta;
  assign unused_inta = wbm_inta_i;
`endif

  typedef enum logic [3:0] {
    S_INIT_PRL, S_INIT_PRH, S_INIT_CTR, S_IDLE, S_TXR, S_CR,
    S_WAIT, S_CHK, S_ERR, S_RXR, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] byte_q, byte_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wd_q, wd_d;
  logic       rxack_q, rxack_d;
  logic       al_q, al_d;
  logic       err_q, err_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       cyc_q, cyc_d;
  logic       we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;

  logic       req_vld, req_we;
  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic [7:0] txr_byte, cr_byte;
  logic       step_done;

  // Byte 0 addresses the slave for write, 1 is the register index, 2 is data or the repeated-START address, 3 is the read.
  always_comb begin
    txr_byte = 8'h00;
    cr_byte  = 8'h91;
    case (byte_q)
      2'd0: begin txr_byte = {dev_q, 1'b0}; cr_byte = 8'h91; end
      2'd1: begin txr_byte = reg_q;         cr_byte = 8'h11; end
      2'd2: begin
        txr_byte = rnw_q ? {dev_q, 1'b1} : wd_q;
        cr_byte  = rnw_q ? 8'h91 : 8'h51;
      end
      default: begin txr_byte = 8'h00; cr_byte = 8'h69; end
    endcase
  end

  always_comb begin
    req_vld = 1'b0;
    req_we  = 1'b1;
    req_adr = ADR_PRL;
    req_dat = 8'h00;
    case (state_q)
      S_INIT_PRL: begin req_vld = 1'b1; req_adr = ADR_PRL; req_dat = PRESCALE[7:0];  end
      S_INIT_PRH: begin req_vld = 1'b1; req_adr = ADR_PRH; req_dat = PRESCALE[15:8]; end
      S_INIT_CTR: begin req_vld = 1'b1; req_adr = ADR_CTR; req_dat = CTR_INIT;       end
      S_TXR:      begin req_vld = 1'b1; req_adr = ADR_TXR; req_dat = txr_byte;       end
      S_CR:       begin req_vld = 1'b1; req_adr = ADR_CR;  req_dat = cr_byte;        end
      S_ERR:      begin req_vld = 1'b1; req_adr = ADR_CR;  req_dat = 8'h41;          end
      S_WAIT: begin
        req_we  = 1'b0;
        req_adr = ADR_CR;
`ifdef I2C_SEQ_IRQ_EN
        req_vld = wbm_inta_i;
`else
        req_vld = 1'b1;
`endif
      end
      S_RXR: begin req_vld = 1'b1; req_we = 1'b0; req_adr = ADR_TXR; end
      default: req_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    rnw_d     = rnw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wd_d      = wd_q;
    rxack_d   = rxack_q;
    al_d      = al_q;
    err_d     = err_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    step_done = cyc_q && wbm_ack_i;

    // A request launches only from an idle bus, so every ack is followed by at least one idle cycle.
    if (!cyc_q && req_vld) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      dat_d = req_dat;
    end else if (step_done) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 3'd0;
      dat_d = 8'h00;
    end

    case (state_q)
      S_INIT_PRL: if (step_done) state_d = S_INIT_PRH;
      S_INIT_PRH: if (step_done) state_d = S_INIT_CTR;
      S_INIT_CTR: if (step_done) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      S_IDLE: if (start_i) begin
        rnw_d     = rnw_i;
        dev_d     = dev_addr_i;
        reg_d     = reg_addr_i;
        wd_d      = wr_data_i;
        byte_d    = 2'd0;
        err_d     = 1'b0;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        state_d   = S_TXR;
      end
      S_TXR: if (step_done) state_d = S_CR;
      S_CR:  if (step_done) state_d = S_WAIT;
      S_ERR: if (step_done) begin
        err_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (step_done) begin
        rxack_d = wbm_dat_i[SR_RXACK];
        al_d    = wbm_dat_i[SR_AL];
`ifdef I2C_SEQ_IRQ_EN
        state_d = S_CHK;
`else
        if (!wbm_dat_i[SR_TIP]) state_d = S_CHK;
`endif
      end
      S_CHK: begin
        if (err_q) begin
          ack_err_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (al_q || (rxack_q && byte_q != 2'd3)) begin
          state_d = S_ERR;
        end else if (byte_q == 2'd3) begin
          state_d = S_RXR;
        end else if (byte_q == 2'd2 && !rnw_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          byte_d  = byte_q + 2'd1;
          state_d = (byte_q == 2'd2) ? S_CR : S_TXR;
        end
      end
      S_RXR: if (step_done) begin
        rd_data_d = wbm_dat_i;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_INIT_PRL;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= S_INIT_PRL;
      byte_q    <= 2'd0;
      rnw_q     <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wd_q      <= 8'd0;
      rxack_q   <= 1'b0;
      al_q      <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 8'd0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 3'd0;
      dat_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      rnw_q     <= rnw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wd_q      <= wd_d;
      rxack_q   <= rxack_d;
      al_q      <= al_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign ack_err_o = ack_err_q;
  assign rd_data_o = rd_data_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Bench for i2c_wb_sequencer: transaction-level model of the I2C core and a slave at 7'h50.
module tb_i2c_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0, rnw_i = 1'b0;
  logic [6:0] dev_addr_i = '0;
  logic [7:0] reg_addr_i = '0, wr_data_i = '0;
  logic       ready_o, busy_o, done_o, ack_err_o;
  logic [7:0] rd_data_o;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_inta_i;

  always #5 clk = ~clk;

  i2c_wb_sequencer #(.PRESCALE(16'h0004)) dut (
    .wb_clk_i(clk), .arst_i(rst_n), .start_i(start_i), .rnw_i(rnw_i),
    .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wr_data_i(wr_data_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .ack_err_o(ack_err_o),
    .rd_data_o(rd_data_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .wbm_inta_i(wbm_inta_i)
  );

  // ---------------- core + slave model ----------------
  localparam int PH_IDLE = 0, PH_REG = 1, PH_DATA = 2, PH_READ = 3;
  logic [7:0]  m_prl, m_prh, m_ctr, m_txr, m_rxr, ptr;
  logic        m_rxack, m_al, m_tip, m_irq, m_ack;
  int          m_tcnt, m_wcnt, ph;
  int          m_lat = 0;
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [10:0] wlog[$];
  logic [7:0]  crlog[$], txlog[$];

  always_comb begin
    case (wbm_adr_o)
      3'd0: wbm_dat_i = m_prl;
      3'd1: wbm_dat_i = m_prh;
      3'd2: wbm_dat_i = m_ctr;
      3'd3: wbm_dat_i = m_rxr;
      3'd4: wbm_dat_i = {m_rxack, 1'b0, m_al, 3'b000, m_tip, m_irq};
      default: wbm_dat_i = 8'h00;
    endcase
  end
  assign wbm_ack_i  = m_ack;
  assign wbm_inta_i = m_irq & m_ctr[6];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack <= 0; m_wcnt <= 0; m_tip <= 0; m_tcnt <= 0; m_irq <= 0;
      m_rxack <= 0; m_al <= 0; m_prl <= 0; m_prh <= 0; m_ctr <= 0;
      m_txr <= 0; m_rxr <= 0; ph <= PH_IDLE; ptr <= 0;
    end else begin
      m_ack <= 1'b0;
      if (m_tcnt > 1) m_tcnt <= m_tcnt - 1;
      else if (m_tcnt == 1) begin m_tcnt <= 0; m_tip <= 1'b0; m_irq <= 1'b1; end
      if (wbm_cyc_o && wbm_stb_o && !m_ack) begin
        if (m_wcnt < m_lat) m_wcnt <= m_wcnt + 1;
        else begin
          m_wcnt <= 0;
          m_ack  <= 1'b1;
          if (wbm_we_o) begin
            wlog.push_back({wbm_adr_o, wbm_dat_o});
            case (wbm_adr_o)
              3'd0: m_prl <= wbm_dat_o;
              3'd1: m_prh <= wbm_dat_o;
              3'd2: m_ctr <= wbm_dat_o;
              3'd3: begin m_txr <= wbm_dat_o; txlog.push_back(wbm_dat_o); end
              3'd4: begin
                crlog.push_back(wbm_dat_o);
                if (wbm_dat_o[4]) begin
                  m_tip <= 1'b1; m_tcnt <= 6;
                  if (wbm_dat_o[7]) begin
                    if (m_txr[7:1] == 7'h50) begin
                      m_rxack <= 1'b0; ph <= m_txr[0] ? PH_READ : PH_REG;
                    end else begin
                      m_rxack <= 1'b1; ph <= PH_IDLE;
                    end
                  end else if (ph == PH_REG) begin
                    ptr <= m_txr; m_rxack <= 1'b0; ph <= PH_DATA;
                  end else if (ph == PH_DATA) begin
                    mem[ptr] <= m_txr; ptr <= ptr + 8'd1; m_rxack <= 1'b0;
                  end else m_rxack <= 1'b1;
                end else if (wbm_dat_o[5]) begin
                  m_tip <= 1'b1; m_tcnt <= 6; m_rxack <= 1'b1;
                  if (ph == PH_READ) begin m_rxr <= mem[ptr]; ptr <= ptr + 8'd1; end
                  else m_rxr <= 8'hEE;
                end else if (wbm_dat_o[6]) begin
                  m_tip <= 1'b1; m_tcnt <= 3;
                end
                if (wbm_dat_o[6]) ph <= PH_IDLE;
                if (wbm_dat_o[0]) m_irq <= 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---------------- bus protocol monitor ----------------
  logic       p_cyc, p_ack, p_we;
  logic [2:0] p_adr;
  logic [7:0] p_dat;
  int         viol = 0;
  int         done_cnt = 0;
  wire mon_bad = (wbm_cyc_o != wbm_stb_o) ||
                 (p_cyc && !p_ack && (!wbm_cyc_o || wbm_adr_o != p_adr || wbm_we_o != p_we ||
                                      (p_we && wbm_dat_o != p_dat))) ||
                 (p_cyc && p_ack && wbm_cyc_o) || (done_o && busy_o) ||
                 (wbm_cyc_o && wbm_we_o && wbm_adr_o == 3'd4 && !wbm_dat_o[0]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cyc <= 0; p_ack <= 0; p_we <= 0; p_adr <= 0; p_dat <= 0;
    end else begin
      if (mon_bad) viol <= viol + 1;
      p_cyc <= wbm_cyc_o; p_ack <= wbm_ack_i; p_we <= wbm_we_o;
      p_adr <= wbm_adr_o; p_dat <= wbm_dat_o;
    end
  end

  always @(posedge clk) if (done_o) done_cnt <= done_cnt + 1;

  // ---------------- checking helpers ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input logic [7:0] act[$], input logic [7:0] exp[$]);
    chk({nm, "_len"}, act.size(), exp.size());
    if (act.size() == exp.size())
      for (int k = 0; k < exp.size(); k++) chk(nm, act[k], exp[k]);
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, ready_o, busy_o, done_o, ack_err_o, rd_data_o, wbm_cyc_o, wbm_stb_o,
            wbm_we_o, wbm_adr_o, wbm_dat_o};
  endfunction

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    chk(nm, ready_o, 1'b1);
  endtask

  task automatic check_init();
    chk("init_len", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("init_prl", wlog[0], {3'd0, 8'h04});
      chk("init_prh", wlog[1], {3'd1, 8'h00});
      chk("init_ctr", wlog[2], {3'd2, 8'h80});
    end
  endtask

  task automatic pulse_start(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd);
    @(negedge clk);
    start_i = 1'b1; rnw_i = rnw; dev_addr_i = dev; reg_addr_i = rg; wr_data_i = wd;
    @(negedge clk);
    start_i = 1'b0; rnw_i = ~rnw; dev_addr_i = 7'h7F; reg_addr_i = ~rg; wr_data_i = ~wd;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done_o && n < 5000) begin @(negedge clk); n++; end
    chk(nm, done_o, 1'b1);
    chk({nm, "_busy_low"}, busy_o, 1'b0);
  endtask

  task automatic run_cmd(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd);
    pulse_start(rnw, dev, rg, wd);
    chk("busy_after_start", busy_o, 1'b1);
    chk("ackerr_cleared", ack_err_o, 1'b0);
    wait_done("done");
  endtask

  typedef struct {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       exp_err;
    logic [7:0] exp_rd;
    logic [7:0] exp_mem;
  } vec_t;

  vec_t vt[7];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ecr[$], etx[$];
    int d0, n;

    vt[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 8'h00, 8'hA5};
    vt[1] = '{1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 8'hA5, 8'hA5};
    vt[2] = '{1'b0, 7'h33, 8'h12, 8'h5A, 1'b1, 8'hA5, 8'hA5};
    vt[3] = '{1'b0, 7'h50, 8'h07, 8'h3C, 1'b0, 8'hA5, 8'h3C};
    vt[4] = '{1'b1, 7'h50, 8'h07, 8'h00, 1'b0, 8'h3C, 8'h3C};
    vt[5] = '{1'b1, 7'h33, 8'h07, 8'h00, 1'b1, 8'h3C, 8'h3C};
    vt[6] = '{1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 8'hA5, 8'hA5};

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    wait_ready("init_ready");
    check_init();

    for (int i = 0; i < 7; i++) begin
      crlog.delete(); txlog.delete();
      m_lat = i % 3;
      d0 = done_cnt;
      run_cmd(vt[i].rnw, vt[i].dev, vt[i].rg, vt[i].wd);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("ack_err", ack_err_o, vt[i].exp_err);
      chk("rd_data", rd_data_o, vt[i].exp_rd);
      chk("slave_mem", mem[vt[i].rg], vt[i].exp_mem);
      if (vt[i].exp_err) begin
        ecr = '{8'h91, 8'h41}; etx = '{{vt[i].dev, 1'b0}};
      end else if (vt[i].rnw) begin
        ecr = '{8'h91, 8'h11, 8'h91, 8'h69};
        etx = '{{vt[i].dev, 1'b0}, vt[i].rg, {vt[i].dev, 1'b1}};
      end else begin
        ecr = '{8'h91, 8'h11, 8'h51};
        etx = '{{vt[i].dev, 1'b0}, vt[i].rg, vt[i].wd};
      end
      cmp_q("cr_seq", crlog, ecr);
      cmp_q("txr_seq", txlog, etx);
    end

    // start while busy is dropped
    m_lat = 1;
    d0 = done_cnt;
    pulse_start(1'b1, 7'h50, 8'h12, 8'h00);
    repeat (10) @(negedge clk);
    pulse_start(1'b0, 7'h50, 8'h20, 8'hFF);
    wait_done("busy_ign_done");
    repeat (300) @(negedge clk);
    chk("busy_ign_count", done_cnt - d0, 1);
    chk("busy_ign_mem", mem[8'h20], 8'h00);
    chk("busy_ign_rd", rd_data_o, 8'hA5);

    // start during init is dropped
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    chk("init_not_ready", ready_o, 1'b0);
    pulse_start(1'b0, 7'h50, 8'h21, 8'h77);
    wait_ready("init2_ready");
    repeat (300) @(negedge clk);
    chk("init_ign_count", done_cnt - d0, 0);
    chk("init_ign_busy", busy_o, 1'b0);
    chk("init_ign_mem", mem[8'h21], 8'h00);

    // reset in the middle of a read
    crlog.delete();
    pulse_start(1'b1, 7'h50, 8'h07, 8'h00);
    n = 0;
    while (crlog.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    chk("midread_progress", crlog.size() >= 2, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("midread_reset_outputs", outs(), 32'd0);
    wlog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reinit_ready");
    check_init();
    run_cmd(1'b1, 7'h50, 8'h07, 8'h00);
    chk("post_reset_rd", rd_data_o, 8'h3C);
    chk("post_reset_err", ack_err_o, 1'b0);

    repeat (5) @(negedge clk);
    chk("protocol_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
